// File: rtl/blend_pkg.sv
// blend_pkg -- shared types and constants for the layer_blend block.
//   state_e      : job sequencer states
//   blend_mode_e : per-channel blend operation (ALPHA, ADD, MUL, COPY)
//   DEF_*        : default frame base addresses / frame length (address units)
//   blend_channel: one 8-bit channel of the blend arithmetic
package blend_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RD_A  = 4'd1,
    WT_A  = 4'd2,
    RD_B  = 4'd3,
    WT_B  = 4'd4,
    BLEND = 4'd5,
    WR1   = 4'd6,
    WR2   = 4'd7,
    NEXT  = 4'd8,
    DONE  = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    ALPHA = 2'd0,
    ADD   = 2'd1,
    MUL   = 2'd2,
    COPY  = 2'd3
  } blend_mode_e;

  localparam int DEF_SRC_A_BASE = 0;
  localparam int DEF_SRC_B_BASE = 65536;
  localparam int DEF_DST_BASE   = 143360;
  localparam int DEF_FRAME_SIZE = 65536;

  // Weight w = alpha + alpha[7] spans 0..256, so alpha=255 returns a exactly
  // and alpha=0 returns b exactly. The weighted sum never exceeds 255*256,
  // so 16 bits hold it without overflow.
  function automatic logic [7:0] blend_channel(input blend_mode_e mode,
                                               input logic [7:0]  a,
                                               input logic [7:0]  b,
                                               input logic [7:0]  alpha);
    logic [8:0]  w;
    logic [15:0] acc;
    logic [8:0]  sum;
    logic [15:0] prod;
    logic [7:0]  y;
    w    = {1'b0, alpha} + {8'd0, alpha[7]};
    acc  = 16'(a) * 16'(w) + 16'(b) * 16'(9'd256 - w);
    sum  = {1'b0, a} + {1'b0, b};
    prod = 16'(a) * 16'(b);
    case (mode)
      ALPHA:   y = 8'(acc >> 8);
      ADD:     y = sum[8] ? 8'hFF : sum[7:0];
      MUL:     y = 8'(prod >> 8);
      default: y = a;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/blend_pixel.sv
// blend_pixel -- combinational blend of one 24-bit pixel (three 8-bit channels).
// Ports:
//   a_i     in  24  layer-A pixel
//   b_i     in  24  layer-B pixel
//   mode_i  in  2   blend operation
//   alpha_i in  8   layer-A weight (ALPHA mode)
//   key_i   in  24  colour key
//   y_o     out 24  blended pixel
// Optional feature macro: BLEND_COLORKEY_EN -- when defined, an A pixel equal
// to key_i passes B through untouched regardless of mode.
module blend_pixel
  import blend_pkg::*;
(
  input  logic [23:0] a_i,
  input  logic [23:0] b_i,
  input  blend_mode_e mode_i,
  input  logic [7:0]  alpha_i,
  input  logic [23:0] key_i,
  output logic [23:0] y_o
);

  logic [23:0] mixed;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    assign mixed[gi*8 +: 8] = blend_channel(mode_i, a_i[gi*8 +: 8],
                                            b_i[gi*8 +: 8], alpha_i);
  end

`ifdef BLEND_COLORKEY_EN
  assign y_o = (a_i == key_i) ? b_i : mixed;
`else
  logic unused_key;
  assign unused_key = ^key_i;
  assign y_o = mixed;
`endif

endmodule

// File: rtl/layer_blend.sv
// layer_blend -- frame blender: reads a block of layer A and layer B from
// SRAM, blends PIX_PER_CYCLE pixels per cycle, writes the block to the
// destination frame, and steps through the whole frame.
// Ports:
//   clk          in  1    clock
//   n_rst        in  1    asynchronous active-low reset
//   start        in  1    job request (honoured only in IDLE)
//   abort        in  1    cancel running job
//   blend_mode   in  2    operation (latched at start)
//   alpha_value  in  8    layer-A weight (latched at start)
//   key_color    in  24   colour key (latched at start when keying is built in)
//   busy         out 1    job active
//   done         out 1    one-cycle completion pulse
//   read_enable  out 1    SRAM read strobe
//   write_enable out 1    SRAM write strobe
//   address      out ADDR_SIZE_BITS SRAM address (0 when idle)
//   read_data    in  BLK  SRAM read block
//   write_data   out BLK  SRAM write block
// Optional feature macro: BLEND_COLORKEY_EN (colour-key pass-through).
module layer_blend
  import blend_pkg::*;
#(
  parameter int ADDR_SIZE_BITS  = 24,
  parameter int WORD_SIZE_BYTES = 3,
  parameter int DATA_SIZE_WORDS = 64,
  parameter int PIX_PER_CYCLE   = 4,
  parameter int SRC_A_BASE      = DEF_SRC_A_BASE,
  parameter int SRC_B_BASE      = DEF_SRC_B_BASE,
  parameter int DST_BASE        = DEF_DST_BASE,
  parameter int FRAME_SIZE      = DEF_FRAME_SIZE
) (
  input  logic                                         clk,
  input  logic                                         n_rst,
  input  logic                                         start,
  input  logic                                         abort,
  input  logic [1:0]                                   blend_mode,
  input  logic [7:0]                                   alpha_value,
  input  logic [23:0]                                  key_color,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         read_enable,
  output logic                                         write_enable,
  output logic [ADDR_SIZE_BITS-1:0]                    address,
  input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
  output logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] write_data
);

  localparam int PIX_BITS     = WORD_SIZE_BYTES * 8;
  localparam int BLK          = PIX_BITS * DATA_SIZE_WORDS;
  localparam int PB           = PIX_BITS * PIX_PER_CYCLE;
  localparam int BLEND_CYCLES = DATA_SIZE_WORDS / PIX_PER_CYCLE;
  localparam int CNT_W        = (BLEND_CYCLES > 1) ? $clog2(BLEND_CYCLES) : 1;

  state_e                    state_q, state_d;
  logic [ADDR_SIZE_BITS-1:0] offset_q, offset_d;
  blend_mode_e               mode_q, mode_d;
  logic [7:0]                alpha_q, alpha_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BLK-1:0]            buf_a_q, buf_a_d;
  logic [BLK-1:0]            buf_b_q, buf_b_d;
  logic [PB-1:0]             res_flat;
  logic [23:0]               key_sel;

`ifdef BLEND_COLORKEY_EN
  logic [23:0] key_q, key_d;
  assign key_sel = key_q;
`else
  logic unused_key_color;
  assign unused_key_color = ^key_color;
  assign key_sel = 24'd0;
`endif

  // The blend lanes always look at the lowest PIX_PER_CYCLE pixels of the
  // buffers; the buffers rotate down each BLEND cycle instead of using a wide
  // variable-index mux.
  for (genvar gi = 0; gi < PIX_PER_CYCLE; gi++) begin : g_lane
    blend_pixel u_pix (
      .a_i    (buf_a_q[gi*PIX_BITS +: 24]),
      .b_i    (buf_b_q[gi*PIX_BITS +: 24]),
      .mode_i (mode_q),
      .alpha_i(alpha_q),
      .key_i  (key_sel),
      .y_o    (res_flat[gi*PIX_BITS +: 24])
    );
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    mode_d   = mode_q;
    alpha_d  = alpha_q;
    cnt_d    = cnt_q;
    buf_a_d  = buf_a_q;
    buf_b_d  = buf_b_q;
`ifdef BLEND_COLORKEY_EN
    key_d    = key_q;
`endif
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_d   = blend_mode_e'(blend_mode);
            alpha_d  = alpha_value;
`ifdef BLEND_COLORKEY_EN
            key_d    = key_color;
`endif
            offset_d = '0;
            state_d  = RD_A;
          end
        end
        RD_A: state_d = WT_A;
        WT_A: begin
          buf_a_d = read_data;
          state_d = RD_B;
        end
        RD_B: state_d = WT_B;
        WT_B: begin
          buf_b_d = read_data;
          cnt_d   = '0;
          state_d = BLEND;
        end
        BLEND: begin
          // Results enter B from the top; after BLEND_CYCLES shifts every
          // result has arrived back at its own pixel position.
          buf_a_d = buf_a_q >> PB;
          buf_b_d = (buf_b_q >> PB) | (BLK'(res_flat) << (BLK - PB));
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BLEND_CYCLES - 1)) begin
            state_d = WR1;
          end
        end
        WR1:  state_d = WR2;
        WR2:  state_d = NEXT;
        NEXT: begin
          offset_d = offset_q + ADDR_SIZE_BITS'(DATA_SIZE_WORDS);
          state_d  = (offset_d == ADDR_SIZE_BITS'(FRAME_SIZE)) ? DONE : RD_A;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobes are masked by abort so a cancelled cycle never touches SRAM.
  always_comb begin
    busy         = (state_q != IDLE);
    done         = (state_q == DONE) && !abort;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    if (!abort) begin
      case (state_q)
        RD_A: begin
          read_enable = 1'b1;
          address     = ADDR_SIZE_BITS'(SRC_A_BASE) + offset_q;
        end
        RD_B: begin
          read_enable = 1'b1;
          address     = ADDR_SIZE_BITS'(SRC_B_BASE) + offset_q;
        end
        WR1, WR2: begin
          write_enable = 1'b1;
          address      = ADDR_SIZE_BITS'(DST_BASE) + offset_q;
        end
        default: ;
      endcase
    end
  end

  // B buffer is blended in place, so it doubles as the write block.
  assign write_data = buf_b_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      offset_q <= '0;
      mode_q   <= ALPHA;
      alpha_q  <= '0;
      cnt_q    <= '0;
      buf_a_q  <= '0;
      buf_b_q  <= '0;
`ifdef BLEND_COLORKEY_EN
      key_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      mode_q   <= mode_d;
      alpha_q  <= alpha_d;
      cnt_q    <= cnt_d;
      buf_a_q  <= buf_a_d;
      buf_b_q  <= buf_b_d;
`ifdef BLEND_COLORKEY_EN
      key_q    <= key_d;
`endif
    end
  end

endmodule

// File: tb/tb_layer_blend.sv
// tb_layer_blend -- randomized scoreboard bench for layer_blend.
// Stimulus pushes expected destination blocks into a queue; a monitor pops
// and compares on every SRAM write. An SRAM responder serves read blocks one
// cycle after each read strobe. Honors BLEND_COLORKEY_EN in its model.
module tb_layer_blend;

  localparam int N     = 64;
  localparam int PIXB  = 24;
  localparam int BLK   = N * PIXB;
  localparam int SRC_B = 65536;
  localparam int DST   = 143360;
  localparam int NBLK  = 1024;
`ifdef BLEND_COLORKEY_EN
  localparam bit KEY_ON = 1'b1;
`else
  localparam bit KEY_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [1:0]      blend_mode = 2'd0;
  logic [7:0]      alpha_value = 8'd0;
  logic [23:0]     key_color = 24'd0;
  logic            busy, done, read_enable, write_enable;
  logic [23:0]     address;
  logic [BLK-1:0]  read_data = '0;
  logic [BLK-1:0]  write_data;

  layer_blend dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .blend_mode(blend_mode), .alpha_value(alpha_value), .key_color(key_color),
    .busy(busy), .done(done), .read_enable(read_enable),
    .write_enable(write_enable), .address(address),
    .read_data(read_data), .write_data(write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0]    addr;
    logic [BLK-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0, wr2_count = 0, rd_count = 0, done_cnt = 0, we_cycles = 0;
  longint cyc = 0, done_cyc = 0, last_wr2_cyc = 0;
  logic [23:0]    last_wr_addr = '0, first_addr = '0;
  logic [BLK-1:0] last_wr_data = '0;
  bit first_pending = 1'b0;

  // Memory content generator configuration
  bit          use_fixed = 1'b1;
  logic [23:0] fix_a = '0, fix_b = '0;
  int unsigned seed = 0;
  bit          inject_key = 1'b0;
  logic [23:0] inj_key = '0;
  // Job configuration as seen by the reference model
  int          job_mode = 0, job_alpha = 0;
  logic [23:0] job_key = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      for (int k = 0; k < N; k++) begin
        if (act[k*PIXB +: PIXB] !== exp[k*PIXB +: PIXB]) begin
          $display("FAIL %s pixel %0d: got %06h required %06h", name, k,
                   act[k*PIXB +: PIXB], exp[k*PIXB +: PIXB]);
          break;
        end
      end
    end
  endtask

  function automatic logic [23:0] gen_pix(bit is_b, int unsigned off, int k);
    int unsigned x;
    if (use_fixed) return is_b ? fix_b : fix_a;
    if (!is_b && inject_key && (k % 5 == 0)) return inj_key;
    x = seed ^ (off * 32'h9E3779B1) ^ (k * 32'h85EBCA6B) ^ (is_b ? 32'hC2B2AE35 : 32'h0);
    x = x ^ (x >> 15); x = x * 32'h2C1B3C6D;
    x = x ^ (x >> 12); x = x * 32'h297A2D39; x = x ^ (x >> 15);
    if (x[31:28] == 4'd0) return 24'hFFFFFF;
    if (x[31:28] == 4'd1) return 24'h000000;
    return x[23:0];
  endfunction

  function automatic logic [BLK-1:0] gen_block(logic [23:0] addr);
    logic [BLK-1:0] blk;
    bit is_b;
    int unsigned off;
    is_b = (addr >= SRC_B);
    off  = is_b ? addr - SRC_B : addr;
    for (int k = 0; k < N; k++) blk[k*PIXB +: PIXB] = gen_pix(is_b, off, k);
    return blk;
  endfunction

  // Reference arithmetic straight from the mode definitions.
  function automatic int chan(int m, int a, int b, int al);
    int w;
    case (m)
      0: begin
        w = al + ((al >= 128) ? 1 : 0);
        return (a * w + b * (256 - w)) / 256;
      end
      1: return (a + b > 255) ? 255 : a + b;
      2: return (a * b) / 256;
      default: return a;
    endcase
  endfunction

  function automatic logic [23:0] model_pix(logic [23:0] a, logic [23:0] b);
    logic [23:0] r;
    if (KEY_ON && (a == job_key)) return b;
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'(chan(job_mode, int'(a[c*8 +: 8]), int'(b[c*8 +: 8]), job_alpha));
    return r;
  endfunction

  task automatic push_expected(input int nblk);
    exp_t e;
    for (int bi = 0; bi < nblk; bi++) begin
      e.addr = 24'(DST + bi * N);
      for (int k = 0; k < N; k++)
        e.data[k*PIXB +: PIXB] = model_pix(gen_pix(1'b0, bi * N, k), gen_pix(1'b1, bi * N, k));
      sb_q.push_back(e);
    end
  endtask

  // SRAM responder: one cycle read latency.
  initial begin
    bit pend;
    logic [23:0] paddr;
    forever begin
      @(negedge clk);
      pend  = read_enable;
      paddr = address;
      @(posedge clk);
      #1;
      if (pend) read_data = gen_block(paddr);
    end
  end

  // Monitor / scoreboard
  initial begin
    bit prev_we = 1'b0;
    logic [23:0] prev_addr = '0;
    logic [BLK-1:0] prev_data = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (read_enable) rd_count++;
      if (write_enable) begin
        we_cycles++;
        if (prev_we && address == prev_addr) begin
          check_blk("wr2_stable", write_data, prev_data);
          wr2_count++;
          last_wr2_cyc = cyc;
        end else begin
          wr_count++;
          last_wr_addr = address;
          last_wr_data = write_data;
          if (first_pending) begin first_addr = address; first_pending = 1'b0; end
          if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_write: got write at %0d, required none", address);
          end else begin
            e = sb_q.pop_front();
            check_val("wr_addr", 32'(address), 32'(e.addr));
            check_blk("wr_data", write_data, e.data);
          end
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      prev_we = write_enable; prev_addr = address; prev_data = write_data;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; start = 1'b0; abort = 1'b0;
    tick(); tick();
    sb_q.delete();
    n_rst = 1'b1;
    tick();
  endtask

  // which: 0 = wr_count, 1 = wr2_count, 2 = rd_count, 3 = done_cnt
  task automatic wait_cnt(input int which, input int target, input int budget, output bit ok);
    int v;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      case (which)
        0: v = wr_count;
        1: v = wr2_count;
        2: v = rd_count;
        default: v = done_cnt;
      endcase
      if (v >= target) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: counter %0d got %0d required %0d", which, v, target);
    end
  endtask

  task automatic set_job(input int m, input int al, input logic [23:0] key);
    job_mode = m; job_alpha = al; job_key = key;
    blend_mode = 2'(m); alpha_value = 8'(al); key_color = key;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the WR2 cycle of a non-final block: aborts in the RD_A cycle.
  task automatic abort_in_rd_a();
    int d0;
    d0 = done_cnt;
    tick(); tick();
    abort = 1'b1;
    #1;
    check_val("abort_re_masked", 32'(read_enable), 0);
    check_val("abort_we_masked", 32'(write_enable), 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_val("abort_busy", 32'(busy), 0);
    repeat (3) tick();
    check_val("abort_no_done", done_cnt, d0);
  endtask

  task automatic run_short(input int nblk);
    bit ok;
    int base;
    push_expected(nblk);
    base = wr2_count;
    pulse_start();
    wait_cnt(1, base + nblk, nblk * 40 + 20, ok);
    if (!ok) begin do_reset(); return; end
    abort_in_rd_a();
  endtask

  function automatic int rand_alpha();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return 0;
      1: return 255;
      2: return 128;
      3: return 127;
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  int          d_mode[6]  = '{0, 0, 0, 1, 2, 3};
  int          d_alpha[6] = '{128, 255, 0, 0, 0, 0};
  logic [23:0] d_a[6]     = '{24'hC8C8C8, 24'hC8C8C8, 24'hC8C8C8, 24'hC8C8C8, 24'hFFFFFF, 24'h111111};
  logic [23:0] d_b[6]     = '{24'h646464, 24'h646464, 24'h646464, 24'h646464, 24'hFFFFFF, 24'h5A3C1E};
  logic [23:0] d_exp[6]   = '{24'h969696, 24'hC8C8C8, 24'h646464, 24'hFFFFFF, 24'hFEFEFE, 24'h111111};

  initial begin
    bit ok;
    int base, d0, w0, m;
    logic [23:0] key;

    // Reset state
    tick(); tick();
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_we", 32'(write_enable), 0);
    n_rst = 1'b1;
    tick();
    check_val("rst_busy_after", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_re", 32'(read_enable), 0);
    check_val("rst_we_after", 32'(write_enable), 0);
    check_val("rst_addr", 32'(address), 0);
    check_blk("rst_wdata", write_data, '0);

    // Directed arithmetic corners
    for (int i = 0; i < 6; i++) begin
      use_fixed = 1'b1; fix_a = d_a[i]; fix_b = d_b[i];
      set_job(d_mode[i], d_alpha[i], 24'h00FF00);
      run_short(1);
      check_val("dir_px_first", 32'(last_wr_data[23:0]), 32'(d_exp[i]));
      check_val("dir_px_last", 32'(last_wr_data[BLK-1 -: 24]), 32'(d_exp[i]));
      $display("directed job %0d mode %0d alpha %0d -> pixel %06h", i, d_mode[i], d_alpha[i], last_wr_data[23:0]);
    end

    // Colour key: A pixel equals key
    use_fixed = 1'b1; fix_a = 24'h00FF00; fix_b = 24'h102030;
    set_job(1, 0, 24'h00FF00);
    run_short(1);
    check_val("colorkey_px", 32'(last_wr_data[23:0]), KEY_ON ? 32'h102030 : 32'h10FF30);
    $display("colorkey job -> pixel %06h", last_wr_data[23:0]);

    // Abort in cycle 3 of BLEND
    use_fixed = 1'b0; seed = $urandom; inject_key = 1'b0;
    set_job(0, 77, 24'h0);
    base = rd_count;
    pulse_start();
    wait_cnt(2, base + 2, 40, ok);
    if (ok) begin
      tick(); tick(); tick(); tick();
      abort = 1'b1;
      #1;
      check_val("blend_abort_we", 32'(write_enable), 0);
      @(posedge clk);
      #1;
      abort = 1'b0;
      check_val("blend_abort_busy", 32'(busy), 0);
      w0 = we_cycles; d0 = done_cnt;
      repeat (30) tick();
      check_val("blend_abort_no_we", we_cycles, w0);
      check_val("blend_abort_no_done", done_cnt, d0);
      $display("abort in BLEND: busy=%0d writes=%0d", busy, we_cycles - w0);
    end else do_reset();

    // Start while busy must be ignored
    use_fixed = 1'b1; fix_a = 24'hC8C8C8; fix_b = 24'h646464;
    set_job(0, 128, 24'h0);
    push_expected(2);
    base = wr2_count;
    pulse_start();
    repeat (5) tick();
    alpha_value = 8'd0; blend_mode = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_cnt(1, base + 2, 100, ok);
    if (ok) begin
      check_val("restart_addr", 32'(last_wr_addr), DST + N);
      check_val("latched_alpha", 32'(last_wr_data[23:0]), 32'h969696);
      $display("start while busy: block addr %0d pixel %06h", last_wr_addr, last_wr_data[23:0]);
      abort_in_rd_a();
    end else do_reset();

    // Randomized short jobs
    for (int j = 0; j < 6; j++) begin
      use_fixed = 1'b0; seed = $urandom; inject_key = 1'b1;
      key = 24'($urandom); inj_key = key;
      m = $urandom_range(0, 3);
      set_job(m, rand_alpha(), key);
      run_short($urandom_range(1, 3));
      $display("random job %0d mode %0d alpha %0d key %06h", j, job_mode, job_alpha, key);
    end

    // Reset mid-job: no write may complete
    use_fixed = 1'b0; seed = $urandom; inject_key = 1'b0;
    set_job(2, 0, 24'h0);
    push_expected(1);
    base = wr_count; w0 = wr2_count;
    pulse_start();
    wait_cnt(0, base + 1, 40, ok);
    n_rst = 1'b0;
    #1;
    check_val("midrst_we", 32'(write_enable), 0);
    check_val("midrst_busy", 32'(busy), 0);
    check_val("midrst_addr", 32'(address), 0);
    tick();
    check_blk("midrst_wdata", write_data, '0);
    n_rst = 1'b1;
    sb_q.delete();
    repeat (5) tick();
    check_val("midrst_no_wr2", wr2_count, w0);
    $display("reset mid-job: write_enable=%0d busy=%0d", write_enable, busy);

    // Full frame, random mode and data
    use_fixed = 1'b0; seed = $urandom; inject_key = 1'b1;
    key = 24'($urandom); inj_key = key;
    set_job($urandom_range(0, 3), rand_alpha(), key);
    push_expected(NBLK);
    first_pending = 1'b1;
    d0 = done_cnt; w0 = wr2_count;
    pulse_start();
    wait_cnt(3, d0 + 1, 30000, ok);
    if (ok) begin
      repeat (5) tick();
      check_val("frame_first_addr", 32'(first_addr), 143360);
      check_val("frame_last_addr", 32'(last_wr_addr), 208832);
      check_val("frame_blocks", wr2_count - w0, NBLK);
      check_val("frame_done_delay", 32'(done_cyc - last_wr2_cyc), 2);
      check_val("frame_done_once", done_cnt - d0, 1);
      check_val("frame_idle", 32'(busy), 0);
      $display("full frame mode %0d alpha %0d: blocks %0d done after %0d cycles", job_mode, job_alpha,
               wr2_count - w0, done_cyc - last_wr2_cyc);
    end else do_reset();

    check_val("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
